// File: rtl/demux8_stage.sv
// demux8_stage: registered 1-to-8 demultiplexer with valid/ready handshake.
// A single-entry buffer holds one word and its destination select; the word is
// offered on exactly one channel and released when that channel accepts.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | nothing held, valid_o = 0, ready to accept
// ST_FULL  | r_data/r_sel held, valid_o = 1 << r_sel until delivered
module demux8_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int SELECT_SIZE = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [SELECT_SIZE-1:0] select_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic [7:0]             valid_o,
    input  logic [7:0]             ready_i,
    input  logic                   flush_i,
    output logic                   dropped_o,
    output logic [15:0]            xfer_count_o
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]             r_state;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [SELECT_SIZE-1:0] r_sel;
    logic [15:0]            r_count;
    logic                   r_dropped;

    logic                   w_full;
    logic                   w_deliver;
    logic                   w_accept;
    logic                   w_drop;

    // Handshake decode; ready is forced low while reset is held so nothing is
    // accepted into a buffer that is being cleared.
    always_comb begin
        w_full    = (r_state == ST_FULL);
        w_deliver = w_full & ready_i[r_sel];
        ready_o   = reset_i & ~flush_i & (~w_full | w_deliver);
        w_accept  = valid_i & ready_o;
        w_drop    = w_full & ~w_deliver & flush_i;
    end

    // One-hot channel valid, suppressed during reset; data is shared by all channels.
    always_comb begin
        valid_o = 8'h00;
        if (reset_i && w_full) begin
            valid_o = 8'(1) << r_sel;
        end
        data_o       = r_data;
        dropped_o    = r_dropped;
        xfer_count_o = r_count;
    end

    // Buffer state machine: delivery takes priority over flush, and a new word
    // may enter on the same edge the held one leaves.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state   <= ST_EMPTY;
            r_data    <= '0;
            r_sel     <= '0;
            r_count   <= 16'h0000;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_drop;
            if (w_deliver) begin
                r_count <= r_count + 16'h0001;
            end
            if (w_accept) begin
                r_data <= data_i;
                r_sel  <= select_i;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_deliver && !w_accept) begin
                        r_state <= ST_EMPTY;
                    end else if (w_drop) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_demux8_stage.sv
// Directed testbench for demux8_stage with hand-computed expectations.
module tb_demux8_stage;

    logic        clk_i;
    logic        reset_i;
    logic [2:0]  select_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic [7:0]  valid_o;
    logic [7:0]  ready_i;
    logic        flush_i;
    logic        dropped_o;
    logic [15:0] xfer_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    demux8_stage #(.DATA_WIDTH(32), .SELECT_SIZE(3)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .select_i     (select_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .flush_i      (flush_i),
        .dropped_o    (dropped_o),
        .xfer_count_o (xfer_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i  = 1'b0;
        select_i = 3'd0;
        data_i   = 32'h0;
        valid_i  = 1'b0;
        ready_i  = 8'h00;
        flush_i  = 1'b0;

        // 1. reset, then a single word on channel 5
        tick();
        tick();
        check("rst_ready_low", 64'(ready_o), 64'd0);
        check("rst_valid_low", 64'(valid_o), 64'd0);
        reset_i = 1'b1;
        #1;
        check("post_rst_ready", 64'(ready_o), 64'd1);
        check("post_rst_valid", 64'(valid_o), 64'd0);
        check("post_rst_count", 64'(xfer_count_o), 64'd0);
        check("post_rst_data", 64'(data_o), 64'd0);
        check("post_rst_drop", 64'(dropped_o), 64'd0);
        valid_i  = 1'b1;
        select_i = 3'd5;
        data_i   = 32'hDEADBEEF;
        tick();
        valid_i = 1'b0;
        #1;
        check("t1_valid", 64'(valid_o), 64'h20);
        check("t1_data", 64'(data_o), 64'hDEADBEEF);
        check("t1_ready_full", 64'(ready_o), 64'd0);
        ready_i = 8'h20;
        tick();
        ready_i = 8'h00;
        check("t1_valid_after", 64'(valid_o), 64'd0);
        check("t1_count", 64'(xfer_count_o), 64'd1);
        check("t1_data_kept", 64'(data_o), 64'hDEADBEEF);

        // 2. back-to-back streaming over all channels
        ready_i = 8'hFF;
        for (int n = 0; n < 8; n++) begin
            valid_i  = 1'b1;
            select_i = 3'(n);
            data_i   = 32'(n);
            #1;
            check($sformatf("t2_ready_%0d", n), 64'(ready_o), 64'd1);
            tick();
            check($sformatf("t2_valid_%0d", n), 64'(valid_o), 64'(8'd1 << n));
            check($sformatf("t2_data_%0d", n), 64'(data_o), 64'(n));
        end
        valid_i = 1'b0;
        tick();
        check("t2_count", 64'(xfer_count_o), 64'd9);
        check("t2_empty", 64'(valid_o), 64'd0);

        // 3. wrong-channel ready is ignored
        ready_i  = 8'h00;
        valid_i  = 1'b1;
        select_i = 3'd2;
        data_i   = 32'hA5A5A5A5;
        tick();
        valid_i = 1'b0;
        ready_i = 8'hFB;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("t3_valid_%0d", k), 64'(valid_o), 64'h04);
            check($sformatf("t3_ready_%0d", k), 64'(ready_o), 64'd0);
            tick();
        end
        check("t3_count_hold", 64'(xfer_count_o), 64'd9);
        check("t3_data_hold", 64'(data_o), 64'hA5A5A5A5);
        ready_i = 8'h04;
        tick();
        ready_i = 8'h00;
        check("t3_delivered", 64'(valid_o), 64'd0);
        check("t3_count", 64'(xfer_count_o), 64'd10);

        // 4. flush of an undelivered word, then flush colliding with delivery
        valid_i  = 1'b1;
        select_i = 3'd3;
        data_i   = 32'h33333333;
        tick();
        valid_i = 1'b0;
        flush_i = 1'b1;
        #1;
        check("t4_ready_flush", 64'(ready_o), 64'd0);
        tick();
        flush_i = 1'b0;
        check("t4_valid", 64'(valid_o), 64'd0);
        check("t4_drop", 64'(dropped_o), 64'd1);
        check("t4_count", 64'(xfer_count_o), 64'd10);
        tick();
        check("t4_drop_once", 64'(dropped_o), 64'd0);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        flush_i = 1'b1;
        ready_i = 8'h08;
        #1;
        check("t4b_ready", 64'(ready_o), 64'd0);
        tick();
        flush_i = 1'b0;
        ready_i = 8'h00;
        check("t4b_count", 64'(xfer_count_o), 64'd11);
        check("t4b_nodrop", 64'(dropped_o), 64'd0);
        check("t4b_valid", 64'(valid_o), 64'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("t4c_empty_flush", 64'(dropped_o), 64'd0);

        // 5. reset while holding a word with count=3
        reset_i = 1'b0;
        tick();
        reset_i  = 1'b1;
        ready_i  = 8'hFF;
        valid_i  = 1'b1;
        select_i = 3'd1;
        for (int k = 0; k < 3; k++) begin
            data_i = 32'(k + 1);
            tick();
        end
        select_i = 3'd6;
        data_i   = 32'h66666666;
        tick();
        valid_i = 1'b0;
        ready_i = 8'h00;
        check("t5_pre_valid", 64'(valid_o), 64'h40);
        check("t5_pre_count", 64'(xfer_count_o), 64'd3);
        reset_i = 1'b0;
        #1;
        check("t5_rst_valid_comb", 64'(valid_o), 64'd0);
        check("t5_rst_ready_comb", 64'(ready_o), 64'd0);
        tick();
        reset_i = 1'b1;
        check("t5_valid", 64'(valid_o), 64'd0);
        check("t5_count", 64'(xfer_count_o), 64'd0);
        check("t5_drop", 64'(dropped_o), 64'd0);
        check("t5_data", 64'(data_o), 64'd0);

        // 6. counter wrap: stream 65537 words at one per clock
        ready_i  = 8'hFF;
        valid_i  = 1'b1;
        select_i = 3'd0;
        data_i   = 32'h12345678;
        for (int k = 1; k <= 65537; k++) begin
            tick();
            if (k == 65536) check("t6_ffff", 64'(xfer_count_o), 64'hFFFF);
            if (k == 65537) check("t6_wrap0", 64'(xfer_count_o), 64'd0);
        end
        valid_i = 1'b0;
        tick();
        check("t6_wrap1", 64'(xfer_count_o), 64'd1);
        check("t6_empty", 64'(valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
